// File: rtl/control_seq.sv
// Microcoded-style control sequencer: fetch, decode and per-opcode
// execute steps driving a 24-bit control word for the datapath.
module control_seq #(
  parameter int MD_CYCLES   = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        con_ff,
  output logic [23:0] ctl,
  output logic [4:0]  alu_op,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned B_PCO    = 0;
  localparam int unsigned B_PCI    = 1;
  localparam int unsigned B_PC_INC = 2;
  localparam int unsigned B_MARI   = 3;
  localparam int unsigned B_MDRI   = 4;
  localparam int unsigned B_MDRO   = 5;
  localparam int unsigned B_IRI    = 6;
  localparam int unsigned B_MEM_RD = 7;
  localparam int unsigned B_MEM_WR = 8;
  localparam int unsigned B_GRA    = 9;
  localparam int unsigned B_GRB    = 10;
  localparam int unsigned B_GRC    = 11;
  localparam int unsigned B_RIN    = 12;
  localparam int unsigned B_ROUT   = 13;
  localparam int unsigned B_BAOUT  = 14;
  localparam int unsigned B_RYI    = 15;
  localparam int unsigned B_RZI    = 16;
  localparam int unsigned B_RZLO   = 17;
  localparam int unsigned B_RZHO   = 18;
  localparam int unsigned B_HII    = 19;
  localparam int unsigned B_LOI    = 20;
  localparam int unsigned B_CSIGNO = 21;
  localparam int unsigned B_CON_IN = 22;
  localparam int unsigned B_ALU_GO = 23;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [4:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_A3, S_A4, S_A5,
    S_M3, S_M4, S_MW, S_M5, S_M6,
    S_L3, S_L4, S_L5, S_L6, S_L7,
    S_S3, S_S4, S_S5, S_S6, S_S7,
    S_B3, S_B4, S_B5, S_B6,
    S_HALT, S_FAULT
  } state_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0] alu_op_q, alu_op_d;

  logic [4:0] opc;
  logic       is_alu;
  logic       mem_to;
  logic       md_done;
  logic       unused_ir;

  assign opc       = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign is_alu    = (opc >= 5'b00101) && (opc <= 5'b01011);
  assign mem_to    = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign md_done   = (cnt_q == CNT_W'(MD_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RESET;
      cnt_q    <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_op_q <= alu_op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    alu_op_d = alu_op_q;
    ctl      = '0;
    unique case (state_q)
      S_RESET: state_d = S_FETCH0;
      S_FETCH0: begin
        ctl[B_PCO]    = 1'b1;
        ctl[B_MARI]   = 1'b1;
        ctl[B_PC_INC] = 1'b1;
        if (run) state_d = S_FETCH1;
      end
      S_FETCH1: begin
        ctl[B_MEM_RD] = 1'b1;
        if (mem_ready) begin
          ctl[B_MDRI] = 1'b1;
          state_d     = S_FETCH2;
        end else if (mem_to) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FETCH2: begin
        ctl[B_MDRO] = 1'b1;
        ctl[B_IRI]  = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        alu_op_d = opc;
        unique case (1'b1)
          is_alu:                          state_d = S_A3;
          (opc == OP_MUL || opc == OP_DIV): state_d = S_M3;
          (opc == OP_LD):                  state_d = S_L3;
          (opc == OP_ST):                  state_d = S_S3;
          (opc == OP_BR):                  state_d = S_B3;
          (opc == OP_NOP):                 state_d = S_FETCH0;
          (opc == OP_HALT):                state_d = S_HALT;
          default:                         state_d = S_FAULT;
        endcase
      end
      S_A3: begin
        ctl[B_GRB]  = 1'b1;
        ctl[B_ROUT] = 1'b1;
        ctl[B_RYI]  = 1'b1;
        state_d     = S_A4;
      end
      S_A4: begin
        ctl[B_GRC]    = 1'b1;
        ctl[B_ROUT]   = 1'b1;
        ctl[B_RZI]    = 1'b1;
        ctl[B_ALU_GO] = 1'b1;
        state_d       = S_A5;
      end
      S_A5: begin
        ctl[B_RZLO] = 1'b1;
        ctl[B_GRA]  = 1'b1;
        ctl[B_RIN]  = 1'b1;
        state_d     = S_FETCH0;
      end
      S_M3: begin
        ctl[B_GRA]  = 1'b1;
        ctl[B_ROUT] = 1'b1;
        ctl[B_RYI]  = 1'b1;
        state_d     = S_M4;
      end
      S_M4: begin
        ctl[B_GRB]    = 1'b1;
        ctl[B_ROUT]   = 1'b1;
        ctl[B_RZI]    = 1'b1;
        ctl[B_ALU_GO] = 1'b1;
        state_d       = S_MW;
      end
      // Idle while the datapath grinds through mul/div
      S_MW: begin
        if (md_done) state_d = S_M5;
        else         cnt_d   = cnt_q + 1'b1;
      end
      S_M5: begin
        ctl[B_RZLO] = 1'b1;
        ctl[B_LOI]  = 1'b1;
        state_d     = S_M6;
      end
      S_M6: begin
        ctl[B_RZHO] = 1'b1;
        ctl[B_HII]  = 1'b1;
        state_d     = S_FETCH0;
      end
      S_L3, S_S3: begin
        ctl[B_GRB]   = 1'b1;
        ctl[B_BAOUT] = 1'b1;
        ctl[B_RYI]   = 1'b1;
        state_d      = (state_q == S_L3) ? S_L4 : S_S4;
      end
      S_L4, S_S4: begin
        ctl[B_CSIGNO] = 1'b1;
        ctl[B_RZI]    = 1'b1;
        state_d       = (state_q == S_L4) ? S_L5 : S_S5;
      end
      S_L5, S_S5: begin
        ctl[B_RZLO] = 1'b1;
        ctl[B_MARI] = 1'b1;
        state_d     = (state_q == S_L5) ? S_L6 : S_S6;
      end
      S_L6: begin
        ctl[B_MEM_RD] = 1'b1;
        if (mem_ready) begin
          ctl[B_MDRI] = 1'b1;
          state_d     = S_L7;
        end else if (mem_to) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_L7: begin
        ctl[B_MDRO] = 1'b1;
        ctl[B_GRA]  = 1'b1;
        ctl[B_RIN]  = 1'b1;
        state_d     = S_FETCH0;
      end
      S_S6: begin
        ctl[B_GRA]  = 1'b1;
        ctl[B_ROUT] = 1'b1;
        ctl[B_MDRI] = 1'b1;
        state_d     = S_S7;
      end
      S_S7: begin
        ctl[B_MEM_WR] = 1'b1;
        if (mem_ready)   state_d = S_FETCH0;
        else if (mem_to) state_d = S_FAULT;
        else             cnt_d   = cnt_q + 1'b1;
      end
      S_B3: begin
        ctl[B_GRA]    = 1'b1;
        ctl[B_ROUT]   = 1'b1;
        ctl[B_CON_IN] = 1'b1;
        state_d       = S_B4;
      end
      S_B4: begin
        ctl[B_PCO] = 1'b1;
        ctl[B_RYI] = 1'b1;
        state_d    = S_B5;
      end
      S_B5: begin
        ctl[B_CSIGNO] = 1'b1;
        ctl[B_RZI]    = 1'b1;
        state_d       = S_B6;
      end
      S_B6: begin
        ctl[B_RZLO] = 1'b1;
        ctl[B_PCI]  = con_ff;
        state_d     = S_FETCH0;
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  assign alu_op = alu_op_q;
  assign halted = (state_q == S_HALT);
  assign fault  = (state_q == S_FAULT);

endmodule

// File: tb/tb_control_seq.sv
// Randomized bench for control_seq: an expected per-cycle trace is
// assembled from instruction-level step lists and replayed on the DUT.
module tb_control_seq;

  localparam int MD = 4;
  localparam int TO = 15;

  localparam logic [23:0] PCO    = 24'h1 << 0;
  localparam logic [23:0] PCI    = 24'h1 << 1;
  localparam logic [23:0] PC_INC = 24'h1 << 2;
  localparam logic [23:0] MARI   = 24'h1 << 3;
  localparam logic [23:0] MDRI   = 24'h1 << 4;
  localparam logic [23:0] MDRO   = 24'h1 << 5;
  localparam logic [23:0] IRI    = 24'h1 << 6;
  localparam logic [23:0] MRD    = 24'h1 << 7;
  localparam logic [23:0] MWR    = 24'h1 << 8;
  localparam logic [23:0] GRA    = 24'h1 << 9;
  localparam logic [23:0] GRB    = 24'h1 << 10;
  localparam logic [23:0] GRC    = 24'h1 << 11;
  localparam logic [23:0] RIN    = 24'h1 << 12;
  localparam logic [23:0] ROUT   = 24'h1 << 13;
  localparam logic [23:0] BAOUT  = 24'h1 << 14;
  localparam logic [23:0] RYI    = 24'h1 << 15;
  localparam logic [23:0] RZI    = 24'h1 << 16;
  localparam logic [23:0] RZLO   = 24'h1 << 17;
  localparam logic [23:0] RZHO   = 24'h1 << 18;
  localparam logic [23:0] HII    = 24'h1 << 19;
  localparam logic [23:0] LOI    = 24'h1 << 20;
  localparam logic [23:0] CSIGNO = 24'h1 << 21;
  localparam logic [23:0] CON_IN = 24'h1 << 22;
  localparam logic [23:0] ALU_GO = 24'h1 << 23;

  logic        clock;
  logic        reset;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic        con_ff;
  logic [23:0] ctl;
  logic [4:0]  alu_op;
  logic        halted;
  logic        fault;

  control_seq #(
    .MD_CYCLES(MD),
    .MEM_TIMEOUT(TO),
    .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .run(run),
    .ir(ir),
    .mem_ready(mem_ready),
    .con_ff(con_ff),
    .ctl(ctl),
    .alu_op(alu_op),
    .halted(halted),
    .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] ctl;
    logic        rdy;
    logic        con;
    logic        run;
    logic [31:0] ir;
    logic [4:0]  alu;
    logic        flt;
    logic        hlt;
  } step_t;

  step_t       q[$];
  logic [4:0]  cur_alu;
  logic [31:0] cur_ir;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic push_full(input logic [23:0] c, input logic rdy,
                           input logic con, input logic rn,
                           input logic f, input logic h);
    step_t s;
    s.ctl = c; s.rdy = rdy; s.con = con; s.run = rn;
    s.ir = cur_ir; s.alu = cur_alu; s.flt = f; s.hlt = h;
    q.push_back(s);
  endtask

  task automatic push(input logic [23:0] c);
    push_full(c, rb(), rb(), rb(), 1'b0, 1'b0);
  endtask

  // d cycles without mem_ready, then the completing cycle
  task automatic rd_wait(input int d);
    repeat (d) push_full(MRD, 1'b0, rb(), rb(), 1'b0, 1'b0);
    push_full(MRD | MDRI, 1'b1, rb(), rb(), 1'b0, 1'b0);
  endtask

  task automatic wr_wait(input int d);
    repeat (d) push_full(MWR, 1'b0, rb(), rb(), 1'b0, 1'b0);
    push_full(MWR, 1'b1, rb(), rb(), 1'b0, 1'b0);
  endtask

  task automatic fetch(input logic [4:0] op, input int hold, input int d);
    cur_ir = {op, 27'($urandom)};
    repeat (hold) push_full(PCO | MARI | PC_INC, rb(), rb(), 1'b0, 1'b0, 1'b0);
    push_full(PCO | MARI | PC_INC, rb(), rb(), 1'b1, 1'b0, 1'b0);
    rd_wait(d);
    push(MDRO | IRI);
    push('0);
    cur_alu = op;
  endtask

  task automatic instr(input logic [4:0] op, input int hold,
                       input int d, input int d2);
    logic c;
    fetch(op, hold, d);
    if (op >= 5'd5 && op <= 5'd11) begin
      push(GRB | ROUT | RYI);
      push(GRC | ROUT | RZI | ALU_GO);
      push(RZLO | GRA | RIN);
    end else if (op == 5'd15 || op == 5'd16) begin
      push(GRA | ROUT | RYI);
      push(GRB | ROUT | RZI | ALU_GO);
      repeat (MD) push('0);
      push(RZLO | LOI);
      push(RZHO | HII);
    end else if (op == 5'd0 || op == 5'd2) begin
      push(GRB | BAOUT | RYI);
      push(CSIGNO | RZI);
      push(RZLO | MARI);
      if (op == 5'd0) begin
        rd_wait(d2);
        push(MDRO | GRA | RIN);
      end else begin
        push(GRA | ROUT | MDRI);
        wr_wait(d2);
      end
    end else if (op == 5'd18) begin
      push(GRA | ROUT | CON_IN);
      push(PCO | RYI);
      push(CSIGNO | RZI);
      c = rb();
      push_full(RZLO | (c ? PCI : 24'h0), rb(), c, rb(), 1'b0, 1'b0);
    end
  endtask

  task automatic play();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(posedge clock);
      #1;
      run = s.run; mem_ready = s.rdy; con_ff = s.con; ir = s.ir;
      @(negedge clock);
      chk("ctl", 32'(ctl), 32'(s.ctl));
      chk("alu_op", 32'(alu_op), 32'(s.alu));
      chk("halt_fault", {30'h0, halted, fault}, {30'h0, s.hlt, s.flt});
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_ctl", 32'(ctl), 32'h0);
    chk("rst_alu", 32'(alu_op), 32'h0);
    chk("rst_flags", {30'h0, halted, fault}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    cur_alu = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  logic [4:0] ops [13];

  initial begin
    ops = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
            5'd15, 5'd16, 5'd0, 5'd2, 5'd18, 5'd26};
    n_checks = 0; n_errors = 0;
    cur_alu = '0; cur_ir = '0;
    run = 1'b0; ir = '0; mem_ready = 1'b0; con_ff = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("reset_ctl", 32'(ctl), 32'h0);
    chk("reset_alu", 32'(alu_op), 32'h0);
    chk("reset_flags", {30'h0, halted, fault}, 32'h0);
    repeat (2) @(negedge clock);
    chk("reset_hold_ctl", 32'(ctl), 32'h0);
    reset = 1'b1;

    // AND with instant memory, then LD with three L6 wait cycles
    instr(5'b01010, 0, 0, 0);
    instr(5'b00000, 0, 0, 3);
    instr(5'b01111, 2, 1, 0);
    instr(5'b10010, 0, 0, 0);
    instr(5'b10010, 0, 0, 0);
    instr(5'b00010, 1, 2, 4);
    play();

    for (int i = 0; i < 40; i++) begin
      instr(ops[$urandom_range(12, 0)], $urandom_range(2, 0),
            $urandom_range(4, 0), $urandom_range(TO - 2, 0));
    end
    play();

    fetch(5'b11011, 0, 0);
    repeat (4) push_full('0, rb(), rb(), rb(), 1'b0, 1'b1);
    play();
    do_reset();

    // Fetch read never completes
    cur_ir = {5'b01010, 27'($urandom)};
    push_full(PCO | MARI | PC_INC, rb(), rb(), 1'b1, 1'b0, 1'b0);
    repeat (TO) push_full(MRD, 1'b0, rb(), rb(), 1'b0, 1'b0);
    repeat (5) push_full('0, 1'b0, rb(), rb(), 1'b1, 1'b0);
    play();
    do_reset();

    fetch(5'b11111, 0, 0);
    repeat (4) push_full('0, rb(), rb(), rb(), 1'b1, 1'b0);
    play();
    do_reset();

    // Reset asserted in the middle of M4
    fetch(5'b01111, 0, 0);
    push(GRA | ROUT | RYI);
    push(GRB | ROUT | RZI | ALU_GO);
    play();
    chk("m4_ctl", 32'(ctl), 32'(GRB | ROUT | RZI | ALU_GO));
    #2 reset = 1'b0;
    #1;
    chk("midreset_ctl", 32'(ctl), 32'h0);
    chk("midreset_alu", 32'(alu_op), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    cur_alu = '0;
    instr(5'b11010, 0, 0, 0);
    instr(5'b01001, 0, 2, 0);
    play();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
